// File: rtl/branch_predict_controller_pkg.sv
// Shared constants for the 2-bit branch predictor: counter encodings, FSM states, default sizing.
package branch_predict_controller_pkg;

    localparam int unsigned DEFAULT_IDX_W = 3;

    localparam logic [1:0] ST    = 2'b00;
    localparam logic [1:0] WT    = 2'b01;
    localparam logic [1:0] WNT   = 2'b10;
    localparam logic [1:0] ST_NT = 2'b11;

    localparam logic [0:0] NORMAL  = 1'b0;
    localparam logic [0:0] RECOVER = 1'b1;

endpackage

// File: rtl/branch_predict_controller_sat_counter2.sv
// One 2-bit saturating predictor entry; taken steps toward ST, not-taken toward ST_NT.
module sat_counter2
    import branch_predict_controller_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       taken,
    output logic [1:0] state
);

    logic [1:0] state_q, state_d;

    always_comb begin
        state_d = state_q;
        if (en) begin
            if (taken) begin
                if (state_q != ST) state_d = state_q - 2'd1;
            end else begin
                if (state_q != ST_NT) state_d = state_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/branch_predict_controller.sv
// Branch predictor table plus misprediction recovery sequencer (redirect, flushes, miss counter).
module branch_predict_controller
    import branch_predict_controller_pkg::*;
#(
    parameter int unsigned IDX_W = DEFAULT_IDX_W,
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             id_branch,
    input  logic [XLEN-1:0]  id_pc,
    output logic             predict_taken,
    input  logic             ex_branch,
    input  logic [XLEN-1:0]  ex_pc,
    input  logic             ex_taken,
    input  logic [XLEN-1:0]  ex_target,
    input  logic             ex_pred_taken,
    output logic             redirect_valid,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic [CNT_W-1:0] mispredict_count
);

    localparam int unsigned ENTRIES = 1 << IDX_W;

    logic [1:0]         ctr [ENTRIES];
    logic [ENTRIES-1:0] ctr_en;
    logic [IDX_W-1:0]   id_idx, ex_idx;
    logic               resolve, mispredict;

    logic [0:0]         state_q, state_d;
    logic               strobe_q, strobe_d;
    logic [XLEN-1:0]    redirect_pc_q, redirect_pc_d;
    logic [CNT_W-1:0]   count_q, count_d;

    // Only the word-index bits of id_pc select an entry.
    logic unused_id_pc;
    assign unused_id_pc = ^{id_pc[XLEN-1:IDX_W+2], id_pc[1:0]};

    assign id_idx = id_pc[IDX_W+1:2];
    assign ex_idx = ex_pc[IDX_W+1:2];

    assign resolve    = ex_branch && !stall && (state_q == NORMAL);
    assign mispredict = resolve && (ex_taken != ex_pred_taken);

    assign predict_taken = id_branch && (state_q == NORMAL) &&
                           ((ctr[id_idx] == ST) || (ctr[id_idx] == WT));

    always_comb begin
        ctr_en         = '0;
        ctr_en[ex_idx] = resolve;
    end

    for (genvar i = 0; i < ENTRIES; i++) begin : g_table
        sat_counter2 u_ctr (
            .clk   (clk),
            .reset (reset),
            .en    (ctr_en[i]),
            .taken (ex_taken),
            .state (ctr[i])
        );
    end

    always_comb begin
        state_d       = state_q;
        strobe_d      = strobe_q;
        redirect_pc_d = redirect_pc_q;
        count_d       = count_q;
        if (state_q == NORMAL) begin
            strobe_d = 1'b0;
            if (mispredict) begin
                state_d       = RECOVER;
                strobe_d      = 1'b1;
                redirect_pc_d = ex_taken ? ex_target : ex_pc + XLEN'(4);
                if (count_q != '1) count_d = count_q + CNT_W'(1);
            end
        end else if (!stall) begin
            // A stalled RECOVER holds the strobes so the pipeline sees them once it moves.
            state_d  = NORMAL;
            strobe_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= NORMAL;
            strobe_q      <= 1'b0;
            redirect_pc_q <= '0;
            count_q       <= '0;
        end else begin
            state_q       <= state_d;
            strobe_q      <= strobe_d;
            redirect_pc_q <= redirect_pc_d;
            count_q       <= count_d;
        end
    end

    assign redirect_valid   = strobe_q;
    assign flush_if_id      = strobe_q;
    assign flush_id_ex      = strobe_q;
    assign redirect_pc      = redirect_pc_q;
    assign mispredict_count = count_q;

endmodule

// File: tb/tb_branch_predict_controller.sv
// Randomised scoreboard bench for branch_predict_controller against a behavioural predictor model.
module tb_branch_predict_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        id_branch = 1'b0;
    logic [31:0] id_pc = '0;
    logic        ex_branch = 1'b0;
    logic [31:0] ex_pc = '0;
    logic        ex_taken = 1'b0;
    logic [31:0] ex_target = '0;
    logic        ex_pred_taken = 1'b0;

    logic        predict_taken, redirect_valid, flush_if_id, flush_id_ex;
    logic [31:0] redirect_pc;
    logic [15:0] mispredict_count;

    logic        s_pred, s_rv, s_fi, s_fe;
    logic [31:0] s_rpc;
    logic [1:0]  s_count;

    always #5 clk = ~clk;

    branch_predict_controller dut (
        .clk(clk), .reset(reset), .stall(stall),
        .id_branch(id_branch), .id_pc(id_pc), .predict_taken(predict_taken),
        .ex_branch(ex_branch), .ex_pc(ex_pc), .ex_taken(ex_taken),
        .ex_target(ex_target), .ex_pred_taken(ex_pred_taken),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
        .mispredict_count(mispredict_count)
    );

    branch_predict_controller #(.CNT_W(2)) dut_small (
        .clk(clk), .reset(reset), .stall(stall),
        .id_branch(id_branch), .id_pc(id_pc), .predict_taken(s_pred),
        .ex_branch(ex_branch), .ex_pc(ex_pc), .ex_taken(ex_taken),
        .ex_target(ex_target), .ex_pred_taken(ex_pred_taken),
        .redirect_valid(s_rv), .redirect_pc(s_rpc),
        .flush_if_id(s_fi), .flush_id_ex(s_fe),
        .mispredict_count(s_count)
    );

    typedef struct {
        logic        pred;
        logic        strobe;
        logic [31:0] rpc;
        int          cnt;
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   errors = 0;

    // Model: confidence 0 (strong taken) .. 3 (strong not-taken) per word index.
    int          m_tab [8];
    bit          m_recover;
    bit          m_strobe;
    logic [31:0] m_rpc;
    int          m_cnt;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, expv, $time);
        end
    endtask

    // Monitor: half a cycle after each edge, compare against the oldest expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (expq.size() > 0) begin
                exp_t e;
                e = expq.pop_front();
                chk("predict_taken", {31'b0, predict_taken}, {31'b0, e.pred});
                chk("redirect_valid", {31'b0, redirect_valid}, {31'b0, e.strobe});
                chk("flush_if_id", {31'b0, flush_if_id}, {31'b0, e.strobe});
                chk("flush_id_ex", {31'b0, flush_id_ex}, {31'b0, e.strobe});
                chk("redirect_pc", redirect_pc, e.rpc);
                chk("mispredict_count", {16'b0, mispredict_count}, 32'(e.cnt));
                chk("small_count", {30'b0, s_count}, 32'((e.cnt > 3) ? 3 : e.cnt));
                chk("small_strobe", {31'b0, s_rv}, {31'b0, e.strobe});
            end
        end
    end

    function automatic bit model_pred(input logic ib, input logic [31:0] pc);
        return ib && !m_recover && (m_tab[int'(pc[4:2])] < 2);
    endfunction

    function automatic exp_t snapshot(input logic ib, input logic [31:0] pc);
        exp_t e;
        e.pred   = model_pred(ib, pc);
        e.strobe = m_strobe;
        e.rpc    = m_rpc;
        e.cnt    = m_cnt;
        return e;
    endfunction

    task automatic model_reset();
        foreach (m_tab[i]) m_tab[i] = 0;
        m_recover = 0;
        m_strobe  = 0;
        m_rpc     = '0;
        m_cnt     = 0;
    endtask

    task automatic step(input logic ib, input logic [31:0] ipc, input logic eb,
                        input logic [31:0] epc, input logic et, input logic [31:0] etg,
                        input logic ept, input logic st);
        int k;
        @(posedge clk);
        #1;
        id_branch = ib; id_pc = ipc; ex_branch = eb; ex_pc = epc;
        ex_taken = et; ex_target = etg; ex_pred_taken = ept; stall = st;
        expq.push_back(snapshot(ib, ipc));
        // Effect of the coming rising edge.
        if (m_recover) begin
            if (!st) begin
                m_recover = 0;
                m_strobe  = 0;
            end
        end else begin
            m_strobe = 0;
            if (eb && !st) begin
                k = int'(epc[4:2]);
                m_tab[k] = et ? ((m_tab[k] > 0) ? m_tab[k] - 1 : 0)
                              : ((m_tab[k] < 3) ? m_tab[k] + 1 : 3);
                if (et != ept) begin
                    m_recover = 1;
                    m_strobe  = 1;
                    m_rpc     = et ? etg : epc + 32'd4;
                    if (m_cnt < 65535) m_cnt++;
                end
            end
        end
    endtask

    task automatic idle();
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    // Reset lands between edges; the next negedge shows whether it acted asynchronously.
    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        id_branch = 0; ex_branch = 0; stall = 0;
        model_reset();
        expq.push_back(snapshot(1'b0, 32'h0));
        @(negedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        logic [31:0] pa, pb, tg;
        logic        t, pt;
        int          wait_cnt;
        model_reset();
        #2;
        do_reset();

        // Directed sequence.
        step(1, 32'h10, 0, 32'h0, 0, 32'h0, 0, 0);
        step(1, 32'h10, 1, 32'h10, 0, 32'h80, 1, 0);
        idle();
        step(1, 32'h10, 1, 32'h10, 0, 32'h80, 1, 0);
        idle();
        step(1, 32'h10, 0, 32'h0, 0, 32'h0, 0, 0);
        step(1, 32'h10, 1, 32'h10, 1, 32'h80, 0, 0);
        idle();
        step(1, 32'h10, 1, 32'h10, 1, 32'h80, 0, 0);
        idle();
        step(1, 32'h10, 1, 32'h10, 0, 32'h40, 1, 0);
        step(0, 32'h0, 1, 32'h10, 1, 32'h80, 0, 1);
        step(0, 32'h0, 1, 32'h10, 1, 32'h80, 0, 1);
        step(0, 32'h0, 1, 32'h10, 1, 32'h80, 0, 1);
        step(1, 32'h10, 1, 32'h10, 1, 32'h80, 0, 0);
        step(1, 32'h10, 0, 32'h0, 0, 32'h0, 0, 0);
        step(1, 32'h4, 1, 32'h4, 1, 32'h100, 1, 0);
        step(1, 32'h4, 1, 32'h4, 0, 32'h100, 1, 1);
        step(1, 32'h4, 1, 32'hFFFF_FFFC, 0, 32'h0, 1, 0);
        do_reset();
        for (int i = 0; i < 8; i++) step(1, 32'(i * 4), 0, 32'h0, 0, 32'h0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            step(0, 32'h0, 1, 32'h8, 1, 32'h200 + 32'(i), 0, 0);
            idle();
        end

        // Randomised traffic.
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end else begin
                pa = ($urandom() & 32'hFFFF_FFE0) | (32'($urandom_range(0, 7)) << 2);
                pb = ($urandom() & 32'hFFFF_FFE0) | (32'($urandom_range(0, 7)) << 2);
                if ($urandom_range(0, 19) == 0) pb = 32'hFFFF_FFFC;
                tg = $urandom() & 32'hFFFF_FFFC;
                t  = 1'($urandom_range(0, 1));
                pt = ($urandom_range(0, 1) == 1) ? model_pred(1'b1, pb) : 1'($urandom_range(0, 1));
                step(1'($urandom_range(0, 1)), pa, 1'($urandom_range(0, 2) != 0), pb, t, tg, pt,
                     $urandom_range(0, 3) == 0);
            end
        end

        wait_cnt = 0;
        while (expq.size() > 0 && wait_cnt < 10) begin
            @(posedge clk);
            wait_cnt++;
        end
        if (expq.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", expq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
